// File: rtl/audio_pkg.sv
// Shared audio types: default sample width, the I2S transmit state enum and the stereo frame record.
package audio_pkg;

    localparam int SAMPLE_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } tx_state_t;

    typedef struct packed {
        logic [SAMPLE_W_DEFAULT-1:0] left;
        logic [SAMPLE_W_DEFAULT-1:0] right;
    } stereo_frame_t;

endpackage

// File: rtl/audio_clk_sync.sv
// Two-flop synchronizer for a codec-driven clock pin, plus a history flop for rise/fall detection.
module audio_clk_sync (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync,
    output logic rise,
    output logic fall
);

    logic meta;
    logic hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= 1'b0;
            sync <= 1'b0;
            hist <= 1'b0;
        end else begin
            meta <= async_in;
            sync <= meta;
            hist <= sync;
        end
    end

    assign rise = sync & ~hist;
    assign fall = hist & ~sync;

endmodule

// File: rtl/i2s_dac_tx.sv
// I2S serializer for the WM8731 DAC input, slaved to the codec's BCLK/LRCK, with a small frame FIFO.
// Optional I2S_DAC_TX_HOLD_LAST_EN: replay the last popped frame on underrun instead of silence.
module i2s_dac_tx
    import audio_pkg::*;
#(
    parameter int SAMPLE_W   = SAMPLE_W_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic [SAMPLE_W-1:0]           left_in,
    input  logic [SAMPLE_W-1:0]           right_in,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          AUD_BCLK,
    input  logic                          AUD_DACLRCK,
    output logic                          AUD_DACDAT,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          underrun,
    output logic [1:0]                    dbg_state
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(SAMPLE_W + 1);
    localparam logic [PTR_W:0]   FULL_LVL = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SAMPLE_W);

    logic bclk_sync, bclk_rise, bclk_fall;
    logic lrck_sync, lrck_rise, lrck_fall;
    logic unused_edges;

    audio_clk_sync u_bclk_sync (
        .clk      (Clk),
        .reset    (Reset),
        .async_in (AUD_BCLK),
        .sync     (bclk_sync),
        .rise     (bclk_rise),
        .fall     (bclk_fall)
    );

    audio_clk_sync u_lrck_sync (
        .clk      (Clk),
        .reset    (Reset),
        .async_in (AUD_DACLRCK),
        .sync     (lrck_sync),
        .rise     (lrck_rise),
        .fall     (lrck_fall)
    );

    // LRCK only matters at BCLK falling edges, so its free-running edges are not used.
    assign unused_edges = bclk_sync ^ bclk_rise ^ lrck_rise ^ lrck_fall;

    tx_state_t             state;
    logic                  lr_q;
    logic [SAMPLE_W-1:0]   shadow_left, shadow_right, shift_reg;
    logic [SAMPLE_W-1:0]   next_left, next_right;
    logic [CNT_W-1:0]      bit_cnt;
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [SAMPLE_W-1:0]   mem_left  [FIFO_DEPTH];
    logic [SAMPLE_W-1:0]   mem_right [FIFO_DEPTH];
    logic                  left_start, right_start, fifo_empty, do_push, do_pop;

    assign left_start  = bclk_fall && lr_q && !lrck_sync;
    assign right_start = bclk_fall && !lr_q && lrck_sync && (state != IDLE);
    assign fifo_empty  = (fifo_level == '0);
    assign in_ready    = (fifo_level != FULL_LVL);
    assign do_push     = in_valid && in_ready;
    assign do_pop      = left_start && !fifo_empty;
    assign dbg_state   = state;

    always_comb begin
        next_left  = mem_left[rd_ptr];
        next_right = mem_right[rd_ptr];
        if (fifo_empty) begin
`ifdef I2S_DAC_TX_HOLD_LAST_EN
            next_left  = shadow_left;
            next_right = shadow_right;
`else
            next_left  = '0;
            next_right = '0;
`endif
        end
    end

    always_ff @(posedge Clk) begin
        if (do_push) begin
            mem_left[wr_ptr]  <= left_in;
            mem_right[wr_ptr] <= right_in;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      fifo_level <= fifo_level + 1'b1;
            else if (!do_push && do_pop) fifo_level <= fifo_level - 1'b1;
        end
    end

    // Each LRCK edge spends one BCLK on the I2S delay slot before the MSB goes out.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state        <= IDLE;
            lr_q         <= 1'b0;
            shadow_left  <= '0;
            shadow_right <= '0;
            shift_reg    <= '0;
            bit_cnt      <= '0;
            AUD_DACDAT   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            underrun <= 1'b0;
            if (bclk_fall) begin
                lr_q <= lrck_sync;
                if (left_start) begin
                    state        <= LEFT;
                    shadow_left  <= next_left;
                    shadow_right <= next_right;
                    shift_reg    <= next_left;
                    bit_cnt      <= '0;
                    AUD_DACDAT   <= 1'b0;
                    underrun     <= fifo_empty;
                end else if (right_start) begin
                    state      <= RIGHT;
                    shift_reg  <= shadow_right;
                    bit_cnt    <= '0;
                    AUD_DACDAT <= 1'b0;
                end else if (state != IDLE && bit_cnt < CNT_MAX) begin
                    AUD_DACDAT <= shift_reg[SAMPLE_W-1];
                    shift_reg  <= {shift_reg[SAMPLE_W-2:0], 1'b0};
                    bit_cnt    <= bit_cnt + 1'b1;
                end else begin
                    AUD_DACDAT <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_i2s_dac_tx.sv
// Directed bench for i2s_dac_tx: drives BCLK/LRCK like the codec, decodes DACDAT and checks words and FIFO state.
module tb_i2s_dac_tx;
    import audio_pkg::*;

    localparam int HALF = 48;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        AUD_BCLK = 1'b1;
    logic        AUD_DACLRCK = 1'b1;
    logic        AUD_DACDAT;
    logic [2:0]  fifo_level;
    logic        underrun;
    logic [1:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_underruns = 0;
    int seen_underruns = 0;
    int lr_pos = HALF;

    logic [15:0]   exp_q[$];
    stereo_frame_t mfifo[$];
    stereo_frame_t mshadow = '0;
    logic          model_lr = 1'b0;
    logic          m_active = 1'b0;
    logic          cap_bit[$];
    logic          cap_start[$];

    i2s_dac_tx dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .left_in     (left_in),
        .right_in    (right_in),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT),
        .fifo_level  (fifo_level),
        .underrun    (underrun),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #10 Clk = ~Clk;

    always @(posedge Clk) if (underrun) seen_underruns <= seen_underruns + 1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        model_lr = 1'b0;
        m_active = 1'b0;
        mshadow  = '0;
        mfifo.delete();
        exp_q.delete();
        cap_bit.delete();
        cap_start.delete();
    endtask

    task automatic model_edge(input logic new_lr);
        if (!new_lr) begin
            if (mfifo.size() > 0) begin
                mshadow = mfifo.pop_front();
            end else begin
                exp_underruns++;
`ifndef I2S_DAC_TX_HOLD_LAST_EN
                mshadow = '0;
`endif
            end
            m_active = 1'b1;
            exp_q.push_back(mshadow.left);
        end else begin
            exp_q.push_back(m_active ? mshadow.right : 16'h0000);
        end
        model_lr = new_lr;
    endtask

    task automatic do_reset(input string tag);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        model_reset();
        check_val({tag, "_dacdat"},   32'(AUD_DACDAT), 32'd0);
        check_val({tag, "_level"},    32'(fifo_level), 32'd0);
        check_val({tag, "_in_ready"}, 32'(in_ready),   32'd1);
        check_val({tag, "_underrun"}, 32'(underrun),   32'd0);
        check_val({tag, "_state"},    32'(dbg_state),  32'(IDLE));
        repeat (8) @(negedge Clk);
    endtask

    // driver: waits (bounded) for in_ready, holds one frame for exactly one accepted cycle
    task automatic push_frame(input stereo_frame_t f);
        logic got;
        got = 1'b0;
        @(negedge Clk);
        left_in  = f.left;
        right_in = f.right;
        in_valid = 1'b1;
        for (int t = 0; t < 5000 && !got; t++) begin
            if (in_ready) got = 1'b1;
            @(negedge Clk);
        end
        in_valid = 1'b0;
        if (got) mfifo.push_back(f);
        else check_val("push_timeout", 32'd0, 32'd1);
    endtask

    // one BCLK = 16 Clk; LRCK changes with the falling BCLK edge, DACDAT is sampled at the rising edge
    task automatic bclk_cycles(input int n, input logic coincide = 1'b0, input stereo_frame_t cf = '0);
        logic new_lr, start;
        for (int i = 0; i < n; i++) begin
            new_lr = (lr_pos >= HALF);
            @(negedge Clk);
            start = (new_lr != model_lr);
            if (start) model_edge(new_lr);
            AUD_BCLK    = 1'b0;
            AUD_DACLRCK = new_lr;
            if (coincide && i == 0) begin
                @(negedge Clk);
                @(negedge Clk);
                check_val("pre_pop_level", 32'(fifo_level), 32'(mfifo.size() + 1));
                left_in  = cf.left;
                right_in = cf.right;
                in_valid = 1'b1;
                @(negedge Clk);
                in_valid = 1'b0;
                mfifo.push_back(cf);
                check_val("pushpop_level", 32'(fifo_level), 32'(mfifo.size()));
                repeat (5) @(negedge Clk);
            end else begin
                repeat (8) @(negedge Clk);
            end
            AUD_BCLK = 1'b1;
            cap_bit.push_back(AUD_DACDAT);
            cap_start.push_back(start);
            repeat (7) @(negedge Clk);
            lr_pos = (lr_pos + 1) % (2 * HALF);
        end
    endtask

    // scoreboard: each slot is delay bit, 16 data bits MSB first, then zeros
    task automatic decode(input string tag);
        int          quiet;
        int          wb;
        logic [15:0] w;
        logic [15:0] cur;
        quiet = 0;
        wb = 0;
        w = '0;
        cur = '0;
        for (int i = 0; i < cap_bit.size(); i++) begin
            if (cap_start[i]) begin
                if (cap_bit[i]) quiet++;
                if (wb != 0) check_val({tag, "_word_cut"}, 32'(wb), 32'd0);
                if (exp_q.size() == 0) begin
                    check_val({tag, "_exp_empty"}, 32'd1, 32'd0);
                    cur = '0;
                end else begin
                    cur = exp_q.pop_front();
                end
                wb = 16;
                w = '0;
            end else if (wb > 0) begin
                w = {w[14:0], cap_bit[i]};
                wb--;
                if (wb == 0) check_val({tag, "_word"}, 32'(w), 32'(cur));
            end else if (cap_bit[i]) begin
                quiet++;
            end
        end
        if (wb != 0) check_val({tag, "_word_cut"}, 32'(wb), 32'd0);
        check_val({tag, "_quiet"},     32'(quiet),          32'd0);
        check_val({tag, "_pending"},   32'(exp_q.size()),   32'd0);
        check_val({tag, "_underruns"}, 32'(seen_underruns), 32'(exp_underruns));
        cap_bit.delete();
        cap_start.delete();
    endtask

    initial begin
        stereo_frame_t f;
        repeat (5) @(negedge Clk);
        do_reset("p0");

        // single frame, reset released with LRCK high
        push_frame('{left: 16'hA5C3, right: 16'h0F01});
        check_val("p1_level", 32'(fifo_level), 32'd1);
        check_val("p1_ready", 32'(in_ready),   32'd1);
        bclk_cycles(5 * HALF);
        decode("p1");
        check_val("p1_level_end", 32'(fifo_level), 32'd0);

        // starved: silence (or replay) and one underrun per left start
        bclk_cycles(4 * HALF);
        decode("p2");

        // BCLK stopped: fill, backpressure, then drain in order
        for (int j = 1; j <= 4; j++) begin
            f.left  = 16'(16'h1100 * j + 16'h0081);
            f.right = 16'(16'h8000 | (16'h0011 * j));
            push_frame(f);
        end
        check_val("p3_level_full", 32'(fifo_level), 32'd4);
        check_val("p3_ready_full", 32'(in_ready),   32'd0);
        @(negedge Clk);
        left_in  = 16'hDEAD;
        right_in = 16'hBEEF;
        in_valid = 1'b1;
        repeat (3) @(negedge Clk);
        check_val("p3_ready_5th", 32'(in_ready),   32'd0);
        check_val("p3_level_5th", 32'(fifo_level), 32'd4);
        in_valid = 1'b0;
        fork
            bclk_cycles(12 * HALF);
            begin
                push_frame('{left: 16'h5A5A, right: 16'hC3C3});
                check_val("p3_level_refill", 32'(fifo_level), 32'd4);
            end
        join
        decode("p3");

        // push lands in the exact cycle of the left-start pop
        push_frame('{left: 16'h7FFF, right: 16'h8000});
        push_frame('{left: 16'h0001, right: 16'hFFFE});
        bclk_cycles(4 * HALF, 1'b1, '{left: 16'h1234, right: 16'h5678});
        decode("p4");
        check_val("p4_level_end", 32'(fifo_level), 32'd1);

        // reset mid left slot after a few bits have gone out
        push_frame('{left: 16'hFFFF, right: 16'hFFFF});
        bclk_cycles(9);
        do_reset("p5rst");
        push_frame('{left: 16'hC001, right: 16'h3FF8});
        bclk_cycles((HALF - 9) + HALF + 2 * HALF);
        decode("p5");

        // reset released inside a right slot: idle until the next left start
        bclk_cycles(HALF);
        decode("p6a");
        bclk_cycles(5);
        do_reset("p6rst");
        push_frame('{left: 16'h9669, right: 16'h0660});
        bclk_cycles((HALF - 5) + 2 * HALF);
        decode("p6");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        repeat (90000) @(posedge Clk);
        n_bad++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
